// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general-purpose register file.
// NRD combinational read ports and NWR write ports share one array. A
// two-state FSM zeroes the whole array one entry per cycle after reset or
// on clr_req, and holds busy high while it does.
// Optional feature: define GPR_MP_BYPASS_EN to forward same-cycle write
// data to matching read ports.
module gpr_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NRD   = 3,
    parameter int NWR   = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic [NRD*AW-1:0]    rd_adr,
    output logic [NRD*WIDTH-1:0] rd_dat,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_adr,
    input  logic [NWR*WIDTH-1:0] wr_dat
);

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    clr_cnt, clr_cnt_nxt;
    logic [WIDTH-1:0] mem [DEPTH];

    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W);
    endfunction

    // FSM state and clear-pointer registers; reset restarts the clear at entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next-state logic: clr_req starts a clear only from IDLE.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_ADR) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // Array update: clear entry while busy, otherwise user writes in port
    // order so the highest-numbered port wins on an address collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int unsigned p = 0; p < NWR; p++) begin
                    if (wr_en[p] && in_range(wr_adr[p*AW +: AW]))
                        mem[wr_adr[p*AW +: AW]] <= wr_dat[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Combinational read ports; zero while busy or out of range.
    always_comb begin
        rd_dat = '0;
        if (!busy) begin
            for (int unsigned i = 0; i < NRD; i++) begin
                if (in_range(rd_adr[i*AW +: AW])) begin
                    rd_dat[i*WIDTH +: WIDTH] = mem[rd_adr[i*AW +: AW]];
`ifdef GPR_MP_BYPASS_EN
                    // Forward only writes that will actually commit this edge.
                    if (!rst) begin
                        for (int unsigned p = 0; p < NWR; p++) begin
                            if (wr_en[p] && (wr_adr[p*AW +: AW] == rd_adr[i*AW +: AW]))
                                rd_dat[i*WIDTH +: WIDTH] = wr_dat[p*WIDTH +: WIDTH];
                        end
                    end
`endif
                end
            end
        end
    end

endmodule

// File: doc/gpr_mp.md
GPR_MP -- requirements
Module: gpr_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers; AW = clog2(DEPTH), minimum 1.
REQ-003 SHALL have parameter NRD, default 3, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..4).
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port clr_req, input, 1, request to zero the whole array.
REQ-008 SHALL have port busy, output, 1, high while the clear sequence runs.
REQ-009 SHALL have port rd_adr, input, NRD*AW, packed read addresses; port i at bits [i*AW +: AW].
REQ-010 SHALL have port rd_dat, output, NRD*WIDTH, packed read data; port i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port wr_en, input, NWR, per-port write enable.
REQ-012 SHALL have port wr_adr, input, NWR*AW, packed write addresses.
REQ-013 SHALL have port wr_dat, input, NWR*WIDTH, packed write data.

Function
REQ-014 SHALL provide combinational read: rd_dat[i] = array[rd_adr[i]] with zero cycles of latency when not busy.
REQ-015 SHALL commit each enabled write at the rising clk edge; the data becomes visible on reads in the next cycle.
REQ-016 SHALL resolve same-address writes in one cycle by port index: the highest-numbered enabled port wins, and the other writes to that address are dropped.
REQ-017 SHALL ignore reads of addresses >= DEPTH and return 0; SHALL ignore writes to addresses >= DEPTH.
REQ-018 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-019 In IDLE, clr_req=1 SHALL move the FSM to CLEAR and load clr_cnt=0.
REQ-020 In CLEAR, each cycle SHALL write 0 to array[clr_cnt] and increment clr_cnt. When clr_cnt=DEPTH-1 is written, the FSM SHALL return to IDLE. A clear therefore takes exactly DEPTH cycles.
REQ-021 busy SHALL equal (state==CLEAR), driven from a register.
REQ-022 While busy, wr_en SHALL be ignored for all ports and rd_dat SHALL read 0 on all ports.
REQ-023 clr_req asserted while in CLEAR SHALL be ignored; the sequence SHALL NOT restart.
REQ-024 The first write accepted after busy falls SHALL land normally; no write SHALL be lost or duplicated across the CLEAR-to-IDLE edge.

Reset
REQ-025 rst=1 at a clk edge SHALL force state=CLEAR and clr_cnt=0. busy SHALL read 1 from the following cycle.
REQ-026 rst asserted mid-clear SHALL restart the clear from entry 0.
REQ-027 rst has priority over clr_req and over all writes in the same cycle.
REQ-028 After rst deasserts, the array SHALL be all-zero and busy=0 exactly DEPTH cycles later.
REQ-029 Outputs during rst SHALL be: busy=1 from the edge following its assertion, and rd_dat=0 on all ports once busy=1.

Configuration
REQ-030 Macro GPR_MP_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With GPR_MP_BYPASS_EN defined and not busy, a read whose address matches an enabled write in the same cycle SHALL return that write's data combinationally. If several writes match, the data comes from the highest-numbered matching port, consistent with REQ-016.
REQ-032 Without GPR_MP_BYPASS_EN, a read SHALL return the pre-write array contents; the new data appears the next cycle.

Verification
REQ-033 rst for 1 cycle, defaults -> busy=1 for exactly 32 cycles; then all 32 addresses read 0 on every port.
REQ-034 wr port0 adr 5 = 0xDEADBEEF and port1 adr 9 = 0x12345678 in the same cycle -> next cycle rd0 adr 5 = 0xDEADBEEF and rd2 adr 9 = 0x12345678.
REQ-035 Both write ports target adr 7 with 0x1111 (port0) and 0x2222 (port1) -> adr 7 reads 0x2222.
REQ-036 Write adr 3 = 0xA5A5A5A5 while rd1 adr 3 in the same cycle -> with GPR_MP_BYPASS_EN, rd1 = 0xA5A5A5A5 that cycle; without it, the old value that cycle and 0xA5A5A5A5 the next.
REQ-037 Fill the array, pulse clr_req, assert rst at clear cycle 10, and issue writes while busy -> the clear restarts, busy lasts 32 cycles after rst, the array ends all-zero, and the busy-time writes are absent.
REQ-038 DEPTH=16, WIDTH=8, NRD=4, NWR=1: write 0xFF to adr 15 and read adr 15 on all 4 ports -> all return 0xFF; a read of adr 16 (AW=4 wraps; instead DEPTH=20, adr 25) -> returns 0.
